prbs31_checker: RTL
===================

# prbs31_checker

Serial PRBS31 (x^31 + x^28 + 1) checker that sits directly downstream of the on-chip PRBS31 generator, either in loopback or on a pin returned from an external link. It self-synchronises to the incoming bit stream and then flags and counts bit errors. It declares loss of lock when the error density in a sliding window exceeds a threshold, and returns to hunting.

## Interface
Parameters:
- ERR_CNT_W, 16: width of the saturating error counter.
- SYNC_MATCHES, 64: consecutive correct predictions required to declare lock.
- LOSS_WINDOW, 64: window length in valid bits used for loss-of-lock detection.
- LOSS_THRESH, 8: errors within one window that force loss of lock.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-high (1 = reset) despite the name.
- din  in  1  received serial PRBS bit.
- din_valid  in  1  din is sampled only on edges where this is 1.
- clr_cnt  in  1  synchronous clear of err_count (and bit_count, if present).
- locked  out  1  1 while in state LOCK.
- err_pulse  out  1  one-cycle pulse for each mismatching valid bit while locked.
- err_count  out  ERR_CNT_W  saturating count of errors seen while locked.
- bit_count  out  32  valid bits checked while locked; present only with PRBS_CHK_BITCNT_EN.

## Operation
- History register hist[30:0]; hist[0] is the most recent bit. Predicted bit: exp = hist[27] ^ hist[30].
- State HUNT:
  - Each valid bit shifts din into hist and increments fill (saturates at 31).
  - Once fill == 31, each valid bit is checked. A match with hist != 0 increments match_cnt; a mismatch, or hist == 0, clears match_cnt.
  - When match_cnt reaches SYNC_MATCHES, go to LOCK, clear the window counters, and set locked.
- State LOCK:
  - Each valid bit shifts exp, not din, into hist. The local LFSR free-runs, so one flipped bit yields exactly one error.
  - If din != exp: err_pulse = 1 and err_count increments, saturating at all-ones.
  - win_bits counts valid bits from 0 to LOSS_WINDOW-1 and wraps; win_errs counts errors in the current window.
  - If win_errs reaches LOSS_THRESH, including on the erroring bit itself, go to HUNT and clear fill, match_cnt and the window counters.
  - At the window wrap, win_errs resets to 0; an error on the wrap bit counts toward the new window.
- hist is not cleared on loss of lock; refill begins from fill = 0.
- clr_cnt and an error on the same edge: the count becomes 1 (the clear applies first).
- din_valid = 0: no state, history or counter changes; err_pulse = 0.
- All-zero input never locks, because of the hist == 0 guard.

## Timing
- Reset values: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0, state HUNT, hist = 0, fill and all counters 0.
- Reset asserted mid-operation returns every register to its reset value on the next edge.
- err_pulse and err_count are registered: both update on the edge that samples the erroneous bit and are visible in the following cycle.
- With din_valid held at 1, locked rises on the edge sampling valid bit 31 + SYNC_MATCHES, which is bit 95 by default.
- locked falls on the edge that samples the LOSS_THRESH-th error of a window.
- No combinational path from inputs to outputs.

## Configuration
- PRBS_CHK_BITCNT_EN:
  - Defined: the 32-bit bit_count port and register exist. The register increments on every valid bit in LOCK, saturates at all-ones, and is cleared by clr_cnt and reset. Together with err_count this gives the bit error rate.
  - Undefined: the port and register are absent.

## Structure
- Package prbs31_pkg:
  - Tap constants PRBS31_LEN = 31, PRBS31_TAP_A = 30, PRBS31_TAP_B = 27.
  - State enum {HUNT, LOCK}.
  - A function prbs31_next(hist) returning the predicted bit.
- Sub-module prbs_loss_window: contains win_bits and win_errs. Inputs: valid, err, clear. Output: a loss strobe when the threshold is reached.
- The top level holds hist, the state machine and the output counters.

## Test plan
- Reference generator seeded with 1, din_valid = 1 constant -> locked = 1 after 95 valid bits; err_count stays 0 over 10,000 bits.
- After lock, invert exactly the 200th bit -> a single err_pulse; err_count = 1; locked stays 1.
- din held at 0 for 500 cycles -> locked never asserts; err_count = 0.
- After lock, invert 8 bits within one 64-bit window -> locked drops on the 8th error; lock is regained 95 clean bits later; err_count = 8.
- din_valid toggled 1,0,1,0 with a clean stream -> lock after 95 valid bits (190 cycles); err_pulse never asserts on invalid cycles.
- Force err_count to 0xFFFE and inject 3 isolated errors -> count holds at 0xFFFF. Then clr_cnt together with an error -> count = 1. Then assert rst_n mid-stream -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/prbs31_pkg.sv
// prbs31_pkg: PRBS31 (x^31 + x^28 + 1) tap constants, checker states and predictor.
package prbs31_pkg;
  localparam int PRBS31_LEN = 31;
  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;
  typedef enum logic {HUNT, LOCK} state_t;
  function automatic logic prbs31_next(input logic [PRBS31_LEN-1:0] hist);
    return hist[PRBS31_TAP_A] ^ hist[PRBS31_TAP_B];
  endfunction
endpackage

// File: rtl/prbs_loss_window.sv
// prbs_loss_window: counts errors per window of valid bits and strobes loss_o when the
// threshold is reached; an error on the wrap bit starts the new window's count.
module prbs_loss_window #(
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic err_i,
  input  logic clear_i,
  output logic loss_o
);
  localparam int BW = LOSS_WINDOW > 1 ? $clog2(LOSS_WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);
  logic [BW-1:0] win_bits_q, win_bits_d;
  logic [EW-1:0] win_errs_q, win_errs_d, errs_base;
  logic wrap;
  always_comb begin
    wrap = win_bits_q == BW'(LOSS_WINDOW - 1);
    errs_base = wrap ? '0 : win_errs_q;
    loss_o = valid_i && err_i && errs_base >= EW'(LOSS_THRESH - 1);
    win_bits_d = clear_i ? '0 : !valid_i ? win_bits_q : wrap ? '0 : win_bits_q + 1'b1;
    win_errs_d = clear_i ? '0 : !valid_i ? win_errs_q : errs_base + EW'(err_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win_bits_q <= '0;
      win_errs_q <= '0;
    end else begin
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
    end
  end
endmodule

// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising PRBS31 bit-error checker with loss-of-lock detection.
// Optional macro PRBS_CHK_BITCNT_EN adds the saturating 32-bit bit_count output.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter int SYNC_MATCHES = 64,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  input  logic clr_cnt,
  output logic locked,
  output logic err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  , output logic [31:0] bit_count
`endif
);
  localparam int MW = $clog2(SYNC_MATCHES + 1);
  state_t state_q, state_d;
  logic [PRBS31_LEN-1:0] hist_q, hist_d;
  logic [4:0] fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
  logic err_pulse_q, exp_bit, err, loss, win_clear, lock_valid;
  always_comb begin
    exp_bit = prbs31_next(hist_q);
    lock_valid = din_valid && state_q == LOCK;
    err = lock_valid && din != exp_bit;
    state_d = state_q;
    hist_d = hist_q;
    fill_d = fill_q;
    match_d = match_q;
    win_clear = 1'b0;
    if (din_valid && state_q == HUNT) begin
      hist_d = {hist_q[PRBS31_LEN-2:0], din};
      fill_d = fill_q == 5'(PRBS31_LEN) ? fill_q : fill_q + 1'b1;
      if (fill_q == 5'(PRBS31_LEN))
        match_d = (din == exp_bit && hist_q != '0) ? match_q + 1'b1 : '0;
      if (match_d == MW'(SYNC_MATCHES)) begin
        state_d = LOCK;
        win_clear = 1'b1;
      end
    end else if (lock_valid) begin
      // The local LFSR free-runs in lock so a flipped input bit never propagates.
      hist_d = {hist_q[PRBS31_LEN-2:0], exp_bit};
      if (loss) begin
        state_d = HUNT;
        fill_d = '0;
        match_d = '0;
        win_clear = 1'b1;
      end
    end
    cnt_base = clr_cnt ? '0 : err_cnt_q;
    err_cnt_d = (err && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
  end
  prbs_loss_window #(.LOSS_WINDOW(LOSS_WINDOW), .LOSS_THRESH(LOSS_THRESH)) u_win (
    .clk(clk),
    .rst(rst_n),
    .valid_i(lock_valid),
    .err_i(err),
    .clear_i(win_clear),
    .loss_o(loss)
  );
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= HUNT;
      hist_q <= '0;
      fill_q <= '0;
      match_q <= '0;
      err_cnt_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      match_q <= match_d;
      err_cnt_q <= err_cnt_d;
      err_pulse_q <= err;
    end
  end
  assign locked = state_q == LOCK;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d, bit_base;
  always_comb begin
    bit_base = clr_cnt ? '0 : bit_cnt_q;
    bit_cnt_d = (lock_valid && bit_base != '1) ? bit_base + 1'b1 : bit_base;
  end
  always_ff @(posedge clk) begin
    if (rst_n) bit_cnt_q <= '0;
    else bit_cnt_q <= bit_cnt_d;
  end
  assign bit_count = bit_cnt_q;
`endif
endmodule
